// File: rtl/instr_register_ctrl.sv
// Write arbiter and circular-queue sequencer for the instr_register array.
// Two round-robin requesters feed a registered write port; reads drain in order.

package instr_register_pkg;
  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic [4:0] address_t;
endpackage

module instr_register_ctrl
  import instr_register_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  opcode_t       req0_opcode,
  input  operand_t      req0_operand_a,
  input  operand_t      req0_operand_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  opcode_t       req1_opcode,
  input  operand_t      req1_operand_a,
  input  operand_t      req1_operand_b,
  output logic          load_en,
  output address_t      write_pointer,
  output opcode_t       opcode,
  output operand_t      operand_a,
  output operand_t      operand_b,
  output address_t      read_pointer,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          last_grant
);

  localparam address_t LastAddr = address_t'(DEPTH - 1);

  logic          load_en_q, load_en_d;
  address_t      write_pointer_q, write_pointer_d;
  opcode_t       opcode_q, opcode_d;
  operand_t      operand_a_q, operand_a_d;
  operand_t      operand_b_q, operand_b_d;
  address_t      read_pointer_q, read_pointer_d;
  address_t      wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rr_q, rr_d;
  logic          last_grant_q, last_grant_d;

  logic gnt0, gnt1, accept, rd_fire;

  assign full       = count_q == CW'(DEPTH);
  assign empty      = count_q == '0;
  // An entry still being written this cycle is counted but not yet readable.
  assign rd_valid   = (count_q - CW'(load_en_q)) != '0;
  assign rd_fire    = rd_valid && rd_ready;
  assign accept     = gnt0 || gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign load_en       = load_en_q;
  assign write_pointer = write_pointer_q;
  assign opcode        = opcode_q;
  assign operand_a     = operand_a_q;
  assign operand_b     = operand_b_q;
  assign read_pointer  = read_pointer_q;
  assign count         = count_q;
  assign last_grant    = last_grant_q;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!full && !flush) begin
      if (req0_valid && req1_valid) begin
        gnt0 = !rr_q;
        gnt1 = rr_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  always_comb begin
    load_en_d       = 1'b0;
    write_pointer_d = write_pointer_q;
    opcode_d        = opcode_q;
    operand_a_d     = operand_a_q;
    operand_b_d     = operand_b_q;
    read_pointer_d  = read_pointer_q;
    wptr_d          = wptr_q;
    count_d         = count_q;
    rr_d            = rr_q;
    last_grant_d    = last_grant_q;
    if (flush) begin
      read_pointer_d = '0;
      wptr_d         = '0;
      count_d        = '0;
      rr_d           = 1'b0;
    end else begin
      if (accept) begin
        load_en_d       = 1'b1;
        write_pointer_d = wptr_q;
        opcode_d        = gnt0 ? req0_opcode    : req1_opcode;
        operand_a_d     = gnt0 ? req0_operand_a : req1_operand_a;
        operand_b_d     = gnt0 ? req0_operand_b : req1_operand_b;
        wptr_d          = (wptr_q == LastAddr) ? '0 : wptr_q + address_t'(1);
        rr_d            = gnt0;
        last_grant_d    = gnt1;
      end
      if (rd_fire) begin
        read_pointer_d = (read_pointer_q == LastAddr) ? '0 : read_pointer_q + address_t'(1);
      end
      unique case ({accept, rd_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_en_q       <= 1'b0;
      write_pointer_q <= '0;
      opcode_q        <= ZERO;
      operand_a_q     <= '0;
      operand_b_q     <= '0;
      read_pointer_q  <= '0;
      wptr_q          <= '0;
      count_q         <= '0;
      rr_q            <= 1'b0;
      last_grant_q    <= 1'b0;
    end else begin
      load_en_q       <= load_en_d;
      write_pointer_q <= write_pointer_d;
      opcode_q        <= opcode_d;
      operand_a_q     <= operand_a_d;
      operand_b_q     <= operand_b_d;
      read_pointer_q  <= read_pointer_d;
      wptr_q          <= wptr_d;
      count_q         <= count_d;
      rr_q            <= rr_d;
      last_grant_q    <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_instr_register_ctrl.sv
// Scoreboard bench for instr_register_ctrl: a reference model predicts grants and
// queues expected writes/reads; a local array stands in for instr_register.
module tb_instr_register_ctrl;
  import instr_register_pkg::*;

  localparam int DEPTH = 32;
  localparam int CW    = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rd_ready = 1'b0;
  opcode_t  req0_opcode = ZERO, req1_opcode = ZERO;
  operand_t req0_operand_a = '0, req0_operand_b = '0, req1_operand_a = '0, req1_operand_b = '0;
  logic req0_ready, req1_ready, load_en, rd_valid, full, empty, last_grant;
  address_t write_pointer, read_pointer;
  opcode_t  opcode;
  operand_t operand_a, operand_b;
  logic [CW-1:0] count;

  instr_register_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_operand_a(req0_operand_a), .req0_operand_b(req0_operand_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_operand_a(req1_operand_a), .req1_operand_b(req1_operand_b),
    .load_en(load_en), .write_pointer(write_pointer), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b), .read_pointer(read_pointer),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .count(count), .full(full),
    .empty(empty), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    address_t ptr;
    opcode_t  op;
    operand_t a;
    operand_t b;
  } wr_t;

  wr_t wq[$];
  wr_t rq[$];
  wr_t mem [DEPTH];

  int total = 0;
  int bad = 0;
  int m_count, m_wptr, m_rptr;
  logic m_rr, m_last, m_load;

  task automatic model_clear();
    m_count = 0; m_wptr = 0; m_rptr = 0;
    m_rr = 1'b0; m_last = 1'b0; m_load = 1'b0;
    wq.delete();
    rq.delete();
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic rand_data();
    req0_opcode = opcode_t'($urandom_range(0, 7));
    req1_opcode = opcode_t'($urandom_range(0, 7));
    req0_operand_a = operand_t'($urandom); req0_operand_b = operand_t'($urandom);
    req1_operand_a = operand_t'($urandom); req1_operand_b = operand_t'($urandom);
  endtask

  // Called at posedge+1; checks handshakes before the next edge, then results after it.
  task automatic tick();
    logic e0, e1, erv;
    wr_t w, r;
    @(negedge clk);
    e0 = 1'b0; e1 = 1'b0;
    if (!flush && m_count != DEPTH) begin
      if (req0_valid && req1_valid) begin
        e0 = !m_rr; e1 = m_rr;
      end else begin
        e0 = req0_valid; e1 = req1_valid;
      end
    end
    erv = (m_count - int'(m_load)) != 0;
    total++;
    if (req0_ready !== e0) begin bad++; $display("FAIL req0_ready: got %b want %b", req0_ready, e0); end
    total++;
    if (req1_ready !== e1) begin bad++; $display("FAIL req1_ready: got %b want %b", req1_ready, e1); end
    total++;
    if (rd_valid !== erv) begin bad++; $display("FAIL rd_valid: got %b want %b", rd_valid, erv); end
    if (flush) begin
      m_count = 0; m_wptr = 0; m_rptr = 0; m_rr = 1'b0; m_load = 1'b0;
      wq.delete();
      rq.delete();
    end else begin
      if (erv && rd_ready) begin
        total++;
        if (rq.size() == 0) begin
          bad++; $display("FAIL read_data: got read want no entry");
        end else begin
          r = rq.pop_front();
          if (mem[m_rptr].op !== r.op || mem[m_rptr].a !== r.a || mem[m_rptr].b !== r.b) begin
            bad++;
            $display("FAIL read_data: got %s %0h %0h want %s %0h %0h", mem[m_rptr].op.name(),
                     mem[m_rptr].a, mem[m_rptr].b, r.op.name(), r.a, r.b);
          end
        end
        m_rptr = (m_rptr + 1) % DEPTH;
        m_count--;
      end
      if (e0 || e1) begin
        w.ptr = address_t'(m_wptr);
        w.op  = e0 ? req0_opcode : req1_opcode;
        w.a   = e0 ? req0_operand_a : req1_operand_a;
        w.b   = e0 ? req0_operand_b : req1_operand_b;
        wq.push_back(w);
        rq.push_back(w);
        m_wptr = (m_wptr + 1) % DEPTH;
        m_count++;
        m_rr = e0;
        m_last = e1;
      end
      m_load = e0 || e1;
    end
    @(posedge clk);
    #1;
    total++;
    if (load_en !== m_load) begin bad++; $display("FAIL load_en: got %b want %b", load_en, m_load); end
    if (load_en === 1'b1) begin
      mem[write_pointer] = '{ptr: write_pointer, op: opcode, a: operand_a, b: operand_b};
      if (m_load) begin
        w = wq.pop_front();
        total++;
        if (write_pointer !== w.ptr || opcode !== w.op || operand_a !== w.a || operand_b !== w.b) begin
          bad++;
          $display("FAIL write_port: got @%0d %s %0h %0h want @%0d %s %0h %0h", write_pointer,
                   opcode.name(), operand_a, operand_b, w.ptr, w.op.name(), w.a, w.b);
        end
      end
    end
    total++;
    if (count !== CW'(m_count)) begin bad++; $display("FAIL count: got %0d want %0d", count, m_count); end
    total++;
    if (read_pointer !== address_t'(m_rptr)) begin
      bad++; $display("FAIL read_pointer: got %0d want %0d", read_pointer, m_rptr);
    end
    total++;
    if (full !== (m_count == DEPTH) || empty !== (m_count == 0)) begin
      bad++; $display("FAIL full_empty: got %b%b want %b%b", full, empty, m_count == DEPTH, m_count == 0);
    end
    total++;
    if (last_grant !== m_last) begin bad++; $display("FAIL last_grant: got %b want %b", last_grant, m_last); end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    idle_inputs();
    #1;
    total++;
    if (load_en !== 1'b0 || count !== '0 || read_pointer !== '0 || write_pointer !== '0 ||
        opcode !== ZERO || last_grant !== 1'b0 || empty !== 1'b1 || full !== 1'b0 ||
        rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got le=%b cnt=%0d rp=%0d wp=%0d op=%s lg=%b e=%b f=%b rv=%b want zeros, empty=1",
               load_en, count, read_pointer, write_pointer, opcode.name(), last_grant, empty, full, rd_valid);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
    rand_data();
    req0_valid = 1'b1;
    #1;
    total++;
    if (req0_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b want 1", req0_ready); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req0_opcode = ADD; req0_operand_a = 5; req0_operand_b = 3; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    total++;
    if (load_en !== 1'b1 || write_pointer !== 5'd0) begin
      bad++; $display("FAIL single_write: got le=%b wp=%0d want le=1 wp=0", load_en, write_pointer);
    end
    tick();
    total++;
    if (rd_valid !== 1'b1 || mem[read_pointer].a + mem[read_pointer].b !== 8) begin
      bad++; $display("FAIL single_result: got rv=%b sum=%0d want rv=1 sum=8", rd_valid,
                      mem[read_pointer].a + mem[read_pointer].b);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    total++;
    if (read_pointer !== 5'd1 || empty !== 1'b1) begin
      bad++; $display("FAIL single_read: got rp=%0d e=%b want rp=1 e=1", read_pointer, empty);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      tick();
      total++;
      if (last_grant !== 1'(i % 2)) begin
        bad++; $display("FAIL rr_order: got %b want %0d at accept %0d", last_grant, i % 2, i);
      end
    end
    idle_inputs();
  endtask

  task automatic test_full_wrap();
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rand_data();
      tick();
    end
    total++;
    if (count !== CW'(DEPTH) || full !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL full: got cnt=%0d f=%b r0=%b r1=%b want 32 1 0 0", count, full,
                      req0_ready, req1_ready);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    total++;
    if (load_en !== 1'b0 || count !== CW'(DEPTH - 1)) begin
      bad++; $display("FAIL no_bypass: got le=%b cnt=%0d want le=0 cnt=31", load_en, count);
    end
    rand_data();
    tick();
    idle_inputs();
    total++;
    if (load_en !== 1'b1 || write_pointer !== 5'd0) begin
      bad++; $display("FAIL wrap_write: got le=%b wp=%0d want le=1 wp=0", load_en, write_pointer);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      tick();
    end
    req0_valid = 1'b0;
    tick();
    rand_data();
    req1_valid = 1'b1; rd_ready = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (count !== CW'(5) || read_pointer !== 5'd1 || write_pointer !== 5'd5) begin
      bad++; $display("FAIL simul: got cnt=%0d rp=%0d wp=%0d want 5 1 5", count, read_pointer,
                      write_pointer);
    end
    do_reset();
    rand_data();
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    total++;
    if (rd_valid !== 1'b0) begin bad++; $display("FAIL inflight_rd: got %b want 0", rd_valid); end
    tick();
    total++;
    if (rd_valid !== 1'b1) begin bad++; $display("FAIL committed_rd: got %b want 1", rd_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    req0_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rand_data();
      tick();
    end
    req1_valid = 1'b1; flush = 1'b1;
    tick();
    total++;
    if (count !== '0 || read_pointer !== '0 || load_en !== 1'b0) begin
      bad++; $display("FAIL flush: got cnt=%0d rp=%0d le=%b want 0 0 0", count, read_pointer, load_en);
    end
    flush = 1'b0;
    rand_data();
    tick();
    idle_inputs();
    total++;
    if (write_pointer !== 5'd0 || last_grant !== 1'b0) begin
      bad++; $display("FAIL post_flush: got wp=%0d lg=%b want 0 0", write_pointer, last_grant);
    end
  endtask

  task automatic test_reset_mid();
    rand_data();
    req0_valid = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    total++;
    if (load_en !== 1'b0 || count !== '0 || read_pointer !== '0 || write_pointer !== '0 ||
        empty !== 1'b1) begin
      bad++; $display("FAIL async_reset: got le=%b cnt=%0d rp=%0d wp=%0d e=%b want 0 0 0 0 1",
                      load_en, count, read_pointer, write_pointer, empty);
    end
    do_reset();
    req0_valid = 1'b1;
    #1;
    total++;
    if (req0_ready !== 1'b1) begin bad++; $display("FAIL ready_after_mid_reset: got %b want 1", req0_ready); end
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_round_robin();
    test_full_wrap();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_register_ctrl.md
# instr_register_ctrl

Write-arbitration and sequencing controller for the 32-entry `instr_register`. It accepts instructions from two independent requesters over valid/ready handshakes and arbitrates between them round-robin. It drives the register's write port (`load_en`, `write_pointer`, `opcode`, operands) and manages the circular read side through `read_pointer`. The register array is used as an in-order queue with occupancy tracking.

## Interface
- `DEPTH`, default 32: entry count; must equal the `instr_register` array size.
- `CW`, default `$clog2(DEPTH)+1`: width of `count`.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous pointer/occupancy clear.
- `req0_valid`  in  1  requester 0 has an instruction.
- `req0_ready`  out  1  requester 0 accepted this cycle.
- `req0_opcode`  in  opcode_t  requester 0 opcode.
- `req0_operand_a`  in  operand_t  requester 0 operand A.
- `req0_operand_b`  in  operand_t  requester 0 operand B.
- `req1_valid`, `req1_ready`, `req1_opcode`, `req1_operand_a`, `req1_operand_b`: same as requester 0, for requester 1.
- `load_en`  out  1  to `instr_register`; registered.
- `write_pointer`  out  address_t  registered write address.
- `opcode`  out  opcode_t  registered write opcode.
- `operand_a`  out  operand_t  registered write operand A.
- `operand_b`  out  operand_t  registered write operand B.
- `read_pointer`  out  address_t  registered read address, oldest unread entry.
- `rd_valid`  out  1  `instruction_word` at `read_pointer` is a committed, unread entry.
- `rd_ready`  in  1  consumer takes that entry.
- `count`  out  CW  accepted, unread entries, including an in-flight write.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `last_grant`  out  1  ID of the most recently accepted requester.

## Operation
- **Accept condition.** A requester is accepted when `reqX_valid && reqX_ready` at a rising edge.
  - At most one requester is accepted per cycle.
  - `reqX_ready` is combinational from `reqX_valid`, `count`, `flush` and the round-robin pointer `rr`.
  - Requesters must not make `valid` depend on `ready`.
- **Grant rule.**
  - If `full` or `flush` is high, both `ready` outputs are 0.
  - Otherwise, if only one `valid` is high, that requester is granted.
  - If both are high, requester `rr` is granted.
  - After any accept, `rr` is set to the non-granted ID and `last_grant` is set to the granted ID.
- **On accept:**
  - `load_en` is set to 1.
  - `write_pointer` is set to `wptr`.
  - `opcode` and both operands are set to the granted requester's fields.
  - `wptr` is set to `wptr+1`, wrapping `DEPTH-1` to 0.
- **No accept.** `load_en` is set to 0. `write_pointer`, `opcode` and operands hold their values.
- **Read side.**
  - `rd_valid = (count - load_en) != 0`: an entry whose write is still in flight is not readable.
  - On `rd_valid && rd_ready`, `read_pointer` advances by 1, wrapping modulo `DEPTH`.
- **Count update.** Accept-only: +1. Read-only: −1. Both in the same cycle: unchanged.
- **No full bypass.** At `count == DEPTH`, accepts stay blocked even if a read occurs in the same cycle. Ready reasserts the cycle after the read.
- **Flush.** Has priority over all other actions.
  - `wptr`, `read_pointer`, `count`, `load_en` and `rr` are set to 0. A pending write is cancelled.
  - `instr_register` contents are untouched.
- **Reset (`reset_n` low).**
  - All registered outputs go to 0 and `opcode` to `ZERO`; `rr` = 0, `last_grant` = 0.
  - Resulting outputs: `empty` = 1, `full` = 0, `rd_valid` = 0.
  - Assertion mid-operation drops any in-flight `load_en` immediately, without waiting for a clock.

## Timing
- **Write latency.** Accept at edge N → `load_en` high during cycle N..N+1 → `instr_register` writes at edge N+1 → `rd_valid` high after edge N+1 (if that was the only entry).
- **Throughput.** One accept per cycle sustained, and one read per cycle sustained.
- **Read data.** `read_pointer` is registered; `instruction_word` is valid combinationally in the same cycle as `rd_valid`.
- **Status outputs.** `count`, `full` and `empty` update at the accepting/reading edge.
- **Reset release.** The first accept is possible on the first edge after `reset_n` deasserts.

## Test plan
- **Reset check.** Assert `reset_n`=0 mid-stream with `load_en`=1 → `load_en`, `count` and pointers go to 0 asynchronously; `empty`=1. After release, `req0_valid` alone gives `req0_ready`=1.
- **Single write/read.** Accept req0 ADD a=5, b=3 at edge 1 → `load_en`=1 with `write_pointer`=0 in cycle 1→2; `rd_valid`=1 after edge 2 and `instruction_word` result = 8. With `rd_ready`=1, `read_pointer` becomes 1 and `empty`=1.
- **Round-robin fairness.** Both requesters valid continuously from reset → grant order 0,1,0,1,…; `last_grant` toggles every cycle.
- **Full and wrap.**
  - 32 accepts with no reads → `count`=32, `full`=1, both `ready`=0.
  - One read → 33rd accept occurs the following cycle at `write_pointer`=0.
- **Simultaneous accept and read.** At `count`=5 → `count` stays 5, both pointers advance. With `count`=1 and `load_en` pending, `rd_valid` is 1 only for the committed entry.
- **Flush.** Flush with `count`=7 and `load_en`=1 → next cycle `count`=0, pointers=0, `load_en`=0; simultaneous `valid`s are not accepted.
